// File: rtl/prog_delay_line.sv
// prog_delay_line: run-time programmable delay line over a circular sample buffer.
module prog_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  input  logic [AW-1:0]    delay_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic             primed
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, fill, dly_q, fill_eff, fill_nxt, dly_nxt;
  logic hit;
  // flush discards history before the current sample is considered
  always_comb begin
    fill_eff = flush ? '0 : fill;
    hit      = fill_eff >= delay_sel;
    fill_nxt = !in_valid ? fill_eff : (fill_eff == AW'(DEPTH - 1)) ? fill_eff : fill_eff + AW'(1);
    dly_nxt  = in_valid ? delay_sel : dly_q;
  end
  always_ff @(posedge clk)
    if (in_valid) mem[wr_ptr] <= D;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr    <= '0;
      fill      <= '0;
      dly_q     <= '0;
      Q         <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      fill      <= fill_nxt;
      dly_q     <= dly_nxt;
      primed    <= fill_nxt >= dly_nxt;
      out_valid <= in_valid && hit;
      if (in_valid) wr_ptr <= wr_ptr + AW'(1);
      if (in_valid && hit) Q <= (delay_sel == '0) ? D : mem[wr_ptr - delay_sel];
    end
endmodule
